// File: rtl/axi_lite_ram_bridge_if.sv
// AXI4-Lite bundle between a bus master and the RAM bridge slave.
interface axi_lite_ram_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   s_araddr;
  logic                s_arvalid;
  logic                s_arready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rvalid;
  logic                s_rready;
  logic [ADDR_W-1:0]   s_awaddr;
  logic                s_awvalid;
  logic                s_awready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wvalid;
  logic                s_wready;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;

  modport master (
    output s_araddr, s_arvalid, s_rready,
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_arready, s_rdata, s_rresp, s_rvalid,
    input  s_awready, s_wready, s_bresp, s_bvalid
  );

  modport slave (
    input  s_araddr, s_arvalid, s_rready,
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_arready, s_rdata, s_rresp, s_rvalid,
    output s_awready, s_wready, s_bresp, s_bvalid
  );
endinterface

// File: rtl/axi_lite_ram_bridge.sv
// AXI4-Lite slave in front of a flat RAM controller port. One transaction
// is in flight at a time; competing reads and writes alternate.
module axi_lite_ram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  axi_lite_ram_bridge_if.slave s,
  output logic [63:0]          ram_raddr,
  input  logic [DATA_W-1:0]    ram_rdata,
  output logic                 ram_rflag,
  output logic [63:0]          ram_waddr,
  output logic [DATA_W-1:0]    ram_wdata,
  output logic [DATA_W-1:0]    ram_wmask,
  output logic                 ram_wen
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_ISSUE, WR_RESP
  } state_t;

  state_t              state_q, state_d;
  logic                active_q, active_d;   // low during reset and the first cycle after
  logic                prio_q, prio_d;       // 0: read wins a tie, 1: write wins
  logic                rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                aw_full_q, aw_full_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic                w_full_q, w_full_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [STRB_W-1:0]   w_strb_q, w_strb_d;
  logic [63:0]         raddr_q, raddr_d;
  logic [63:0]         waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   wmask_exp;
  logic                ar_hs, aw_hs, w_hs, rd_ok, wr_ok;

  // Each strobe bit widens to a full byte of the RAM bit mask.
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_mask
    assign wmask_exp[gi*8 +: 8] = {8{w_strb_q[gi]}};
  end

  assign s.s_arready = active_q && (state_q == IDLE) && !rd_pend_q;
  assign s.s_awready = active_q && !aw_full_q;
  assign s.s_wready  = active_q && !w_full_q;
  assign s.s_rvalid  = (state_q == RD_RESP);
  assign s.s_bvalid  = (state_q == WR_RESP);
  assign s.s_rresp   = 2'b00;
  assign s.s_bresp   = 2'b00;
  assign s.s_rdata   = rdata_q;

  assign ram_rflag = (state_q == RD_ISSUE);
  assign ram_wen   = (state_q == WR_ISSUE);
  assign ram_raddr = raddr_q;
  assign ram_waddr = waddr_q;
  assign ram_wdata = wdata_q;
  assign ram_wmask = wmask_q;

  assign ar_hs = s.s_arvalid && s.s_arready;
  assign aw_hs = s.s_awvalid && s.s_awready;
  assign w_hs  = s.s_wvalid && s.s_wready;
  assign rd_ok = rd_pend_q;
  assign wr_ok = aw_full_q && w_full_q;

  // Request capture, arbitration and issue sequencing.
  always_comb begin
    state_d   = state_q;
    active_d  = 1'b1;
    prio_d    = prio_q;
    rd_pend_d = rd_pend_q;
    rd_addr_d = rd_addr_q;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    rdata_d   = rdata_q;

    if (ar_hs) begin
      rd_pend_d = 1'b1;
      rd_addr_d = s.s_araddr;
    end
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = s.s_awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s.s_wdata;
      w_strb_d = s.s_wstrb;
    end

    case (state_q)
      IDLE: begin
        // RAM addresses are loaded on the grant so they are valid throughout the issue cycle.
        if (rd_ok && (!wr_ok || !prio_q)) begin
          state_d = RD_ISSUE;
          prio_d  = ~prio_q;
          raddr_d = 64'(rd_addr_q) & ~64'h7;
        end else if (wr_ok) begin
          state_d = WR_ISSUE;
          prio_d  = ~prio_q;
          waddr_d = 64'(aw_addr_q) & ~64'h7;
          wdata_d = w_data_q;
          wmask_d = wmask_exp;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        rdata_d = ram_rdata;
        state_d = RD_RESP;
      end
      RD_RESP: begin
        if (s.s_rready) begin
          rd_pend_d = 1'b0;
          state_d   = IDLE;
        end
      end
      WR_ISSUE: begin
        aw_full_d = 1'b0;
        w_full_d  = 1'b0;
        state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (s.s_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      active_q  <= 1'b0;
      prio_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      prio_q    <= prio_d;
      rd_pend_q <= rd_pend_d;
      rd_addr_q <= rd_addr_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      rdata_q   <= rdata_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_ram_bridge.sv
// Bench for axi_lite_ram_bridge: a small RAM behind the bridge and a
// byte-level reference memory checked against every AXI read.
module tb_axi_lite_ram_bridge;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  axi_lite_ram_bridge_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  logic [63:0] ram_raddr, ram_rdata, ram_waddr, ram_wdata, ram_wmask;
  logic        ram_rflag, ram_wen;

  axi_lite_ram_bridge #(.ADDR_W(32), .DATA_W(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .s         (bus),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .ram_rflag (ram_rflag),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_wmask (ram_wmask),
    .ram_wen   (ram_wen)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RAM controller stand-in: registered read, masked write, 64 words.
  logic [63:0] ram_mem [64];
  logic        ram_clr = 1'b1;
  logic        pre_en  = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [63:0] pre_dat = '0;
  initial ram_rdata = '0;
  always @(posedge clock) begin
    ram_rdata <= ram_mem[ram_raddr[8:3]];
    if (ram_clr) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= '0;
    end else if (pre_en) begin
      ram_mem[pre_idx] <= pre_dat;
    end else if (ram_wen) begin
      ram_mem[ram_waddr[8:3]] <= (ram_mem[ram_waddr[8:3]] & ~ram_wmask) | (ram_wdata & ram_wmask);
    end
  end

  // Reference: byte-addressed memory updated from AXI writes only.
  logic [7:0] ref_bytes [512];
  int grants = 0;

  function automatic logic [63:0] ref_word(input logic [31:0] a);
    logic [63:0] w;
    int base;
    base = int'(a[8:3]) * 8;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = ref_bytes[base + i];
    return w;
  endfunction

  function automatic logic [63:0] strb_to_mask(input logic [7:0] st);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) if (st[i]) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Cycle counter and RAM-side monitor.
  int          cyc = 0;
  int          n_rflag = 0, n_wen = 0, n_grant = 0, rflag_cyc = 0;
  logic [1:0]  grant_hist = '0;
  logic [63:0] last_raddr = '0, last_waddr = '0, last_wdata = '0, last_wmask = '0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (ram_rflag || ram_wen) begin
      check("rflag_wen_excl", 64'(ram_rflag && ram_wen), 64'h0);
      grant_hist <= {grant_hist[0], ram_wen};
      n_grant    <= n_grant + 1;
    end
    if (ram_rflag) begin
      n_rflag    <= n_rflag + 1;
      rflag_cyc  <= cyc;
      last_raddr <= ram_raddr;
    end
    if (ram_wen) begin
      n_wen      <= n_wen + 1;
      last_waddr <= ram_waddr;
      last_wdata <= ram_wdata;
      last_wmask <= ram_wmask;
    end
  end

  task automatic check_quiet(input string pfx);
    check({pfx, "_arready"}, 64'(bus.s_arready), 64'h0);
    check({pfx, "_awready"}, 64'(bus.s_awready), 64'h0);
    check({pfx, "_wready"},  64'(bus.s_wready),  64'h0);
    check({pfx, "_rvalid"},  64'(bus.s_rvalid),  64'h0);
    check({pfx, "_bvalid"},  64'(bus.s_bvalid),  64'h0);
    check({pfx, "_rflag"},   64'(ram_rflag),     64'h0);
    check({pfx, "_wen"},     64'(ram_wen),       64'h0);
    check({pfx, "_raddr"},   ram_raddr,          64'h0);
    check({pfx, "_waddr"},   ram_waddr,          64'h0);
    check({pfx, "_wdata"},   ram_wdata,          64'h0);
    check({pfx, "_wmask"},   ram_wmask,          64'h0);
    check({pfx, "_rdata"},   bus.s_rdata,        64'h0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int stall, output logic [63:0] d,
                          output int c_ar, output int c_rv);
    int n;
    int rf0;
    logic [63:0] d0;
    rf0 = n_rflag;
    @(negedge clock);
    bus.s_araddr  = a;
    bus.s_arvalid = 1'b1;
    bus.s_rready  = 1'b0;
    n = 0;
    while (!bus.s_arready && n < 200) begin @(negedge clock); n++; end
    check("ar_timeout", 64'(n < 200), 64'h1);
    @(posedge clock); #1;
    c_ar = cyc;
    bus.s_arvalid = 1'b0;
    @(negedge clock);
    n = 0;
    while (!bus.s_rvalid && n < 200) begin @(negedge clock); n++; end
    check("r_timeout", 64'(n < 200), 64'h1);
    c_rv = cyc;
    d0 = bus.s_rdata;
    for (int i = 0; i < stall; i++) begin
      check("r_hold_valid", 64'(bus.s_rvalid), 64'h1);
      check("r_hold_data", bus.s_rdata, d0);
      check("ar_blocked", 64'(bus.s_arready), 64'h0);
      @(negedge clock);
    end
    check("rresp", 64'(bus.s_rresp), 64'h0);
    d = bus.s_rdata;
    bus.s_rready = 1'b1;
    @(posedge clock); #1;
    bus.s_rready = 1'b0;
    grants++;
    check("rflag_count", 64'(n_rflag - rf0), 64'h1);
    check("raddr", last_raddr, {32'h0, a[31:3], 3'b000});
    $display("RD addr=%h data=%h stall=%0d", a, d, stall);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [63:0] dat, input logic [7:0] st,
                           input int da, input int dw, input int bstall);
    int k;
    int wen0;
    bit aw_done, w_done, hsa, hsw;
    wen0 = n_wen;
    aw_done = 1'b0;
    w_done  = 1'b0;
    k = 0;
    while (!(aw_done && w_done) && k < 200) begin
      @(negedge clock);
      bus.s_awaddr  = a;
      bus.s_wdata   = dat;
      bus.s_wstrb   = st;
      bus.s_awvalid = !aw_done && (k >= da);
      bus.s_wvalid  = !w_done && (k >= dw);
      hsa = bus.s_awvalid && bus.s_awready;
      hsw = bus.s_wvalid && bus.s_wready;
      @(posedge clock); #1;
      if (hsa) begin aw_done = 1'b1; bus.s_awvalid = 1'b0; end
      if (hsw) begin w_done = 1'b1; bus.s_wvalid = 1'b0; end
      k++;
    end
    check("aw_w_timeout", 64'(aw_done && w_done), 64'h1);
    @(negedge clock);
    k = 0;
    while (!bus.s_bvalid && k < 200) begin @(negedge clock); k++; end
    check("b_timeout", 64'(k < 200), 64'h1);
    for (int i = 0; i < bstall; i++) begin
      check("b_hold_valid", 64'(bus.s_bvalid), 64'h1);
      @(negedge clock);
    end
    check("bresp", 64'(bus.s_bresp), 64'h0);
    bus.s_bready = 1'b1;
    @(posedge clock); #1;
    bus.s_bready = 1'b0;
    grants++;
    check("wen_count", 64'(n_wen - wen0), 64'h1);
    check("waddr", last_waddr, {32'h0, a[31:3], 3'b000});
    check("wdata", last_wdata, dat);
    check("wmask", last_wmask, strb_to_mask(st));
    for (int i = 0; i < 8; i++)
      if (st[i]) ref_bytes[int'(a[8:3]) * 8 + i] = dat[i*8 +: 8];
    $display("WR addr=%h data=%h strb=%h", a, dat, st);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] d;
    logic [63:0] pre;
    int c_ar, c_rv, n, g0;
    logic [1:0] exp_hist;

    bus.s_araddr = '0; bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0;
    bus.s_wdata  = '0; bus.s_wstrb   = '0;   bus.s_wvalid = 1'b0;
    bus.s_bready = 1'b0;
    for (int i = 0; i < 512; i++) ref_bytes[i] = 8'h00;

    // Reset state, then preload word 0x80000008.
    repeat (3) @(negedge clock);
    check_quiet("reset");
    ram_clr = 1'b0;
    pre = 64'h1122334455667788;
    pre_en = 1'b1; pre_idx = 6'd1; pre_dat = pre;
    for (int i = 0; i < 8; i++) ref_bytes[8 + i] = pre[i*8 +: 8];
    @(negedge clock);
    pre_en = 1'b0;
    reset  = 1'b1;

    // Basic read with latency checks.
    axi_read(32'h8000000C, 0, d, c_ar, c_rv);
    check("rd_data", d, ref_word(32'h8000000C));
    check("lat_rflag", 64'(rflag_cyc), 64'(c_ar + 1));
    check("lat_rvalid", 64'(c_rv), 64'(c_ar + 3));

    // W before AW, then read back.
    axi_write(32'h80000010, 64'hAABBCCDD00000000, 8'hF0, 3, 0, 1);
    axi_read(32'h80000010, 0, d, c_ar, c_rv);
    check("wr_readback", d, ref_word(32'h80000010));

    // Read backpressure.
    axi_read(32'h80000008, 5, d, c_ar, c_rv);
    check("bp_data", d, ref_word(32'h80000008));

    // Zero strobe still completes but leaves memory untouched.
    axi_write(32'h80000008, 64'hDEADBEEFCAFEF00D, 8'h00, 0, 0, 0);
    axi_read(32'h80000008, 0, d, c_ar, c_rv);
    check("zero_strb_data", d, ref_word(32'h80000008));

    // Reset while the read is waiting on the RAM.
    @(negedge clock);
    bus.s_araddr = 32'h80000008; bus.s_arvalid = 1'b1; bus.s_rready = 1'b0;
    n = 0;
    while (!bus.s_arready && n < 200) begin @(negedge clock); n++; end
    check("rst_ar_timeout", 64'(n < 200), 64'h1);
    @(posedge clock); #1;
    bus.s_arvalid = 1'b0;
    @(posedge clock); #1;
    check("rst_pre_rflag", 64'(ram_rflag), 64'h1);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check_quiet("midrst");
    @(negedge clock); @(negedge clock);
    reset  = 1'b1;
    grants = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("no_stale_rvalid", 64'(bus.s_rvalid), 64'h0);
    end

    // Read and write presented together; the tie winner alternates per grant.
    exp_hist = (grants % 2 == 0) ? 2'b01 : 2'b10;
    g0 = n_grant;
    fork
      axi_read(32'h80000008, 0, d, c_ar, c_rv);
      axi_write(32'h80000020, 64'h0123456789ABCDEF, 8'hFF, 0, 0, 0);
    join
    check("tie1_data", d, ref_word(32'h80000008));
    check("tie1_grants", 64'(n_grant - g0), 64'h2);
    check("tie1_order", 64'(grant_hist), 64'(exp_hist));

    axi_read(32'h80000010, 0, d, c_ar, c_rv);
    check("mid_data", d, ref_word(32'h80000010));

    exp_hist = (grants % 2 == 0) ? 2'b01 : 2'b10;
    g0 = n_grant;
    fork
      axi_read(32'h80000020, 2, d, c_ar, c_rv);
      axi_write(32'h80000030, 64'hFEEDFACE12345678, 8'h3C, 0, 0, 1);
    join
    check("tie2_data", d, ref_word(32'h80000020));
    check("tie2_grants", 64'(n_grant - g0), 64'h2);
    check("tie2_order", 64'(grant_hist), 64'(exp_hist));

    // Randomised mix of reads, writes and concurrent pairs.
    for (int it = 0; it < 60; it++) begin
      int op, ridx, widx;
      logic [31:0] ra, wa;
      logic [63:0] wd;
      logic [7:0] ws;
      op   = int'($urandom_range(0, 2));
      ridx = int'($urandom_range(0, 15));
      widx = int'($urandom_range(0, 15));
      if (widx == ridx) widx = (widx + 1) % 16;
      ra = 32'h80000000 + 32'(ridx * 8) + 32'($urandom_range(0, 7));
      wa = 32'h80000000 + 32'(widx * 8) + 32'($urandom_range(0, 7));
      wd = {$urandom, $urandom};
      ws = 8'($urandom);
      if (op == 0) begin
        axi_read(ra, int'($urandom_range(0, 3)), d, c_ar, c_rv);
        check("rnd_rd", d, ref_word(ra));
      end else if (op == 1) begin
        axi_write(wa, wd, ws, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)));
      end else begin
        fork
          axi_read(ra, int'($urandom_range(0, 3)), d, c_ar, c_rv);
          axi_write(wa, wd, ws, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)));
        join
        check("rnd_pair_rd", d, ref_word(ra));
      end
    end

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
